// File: rtl/uart_fifo_top.sv
// UART top with run-time baud divisor, show-ahead TX/RX FIFOs, level/status
// outputs and sticky error flags, plus the shared package and TX/RX engines.
package uart_pkg;
  typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_e;
endpackage

module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // A pop in the same cycle never makes room for a push into a full FIFO.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_tx #(
  parameter int unsigned       DATA_BITS   = 8,
  parameter int unsigned       STOP_BITS   = 1,
  parameter uart_pkg::parity_e PARITY_MODE = uart_pkg::PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_tick,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 txd
);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  tx_state_e            state, state_n;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           cnt;
  logic                 par_bit, txd_n, load, shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      txd     <= 1'b1;
      shreg   <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
    end else begin
      state <= state_n;
      txd   <= txd_n;
      if (load) begin
        shreg   <= data;
        par_bit <= (PARITY_MODE == uart_pkg::PARITY_ODD) ? ~^data : ^data;
      end else if (shift) begin
        shreg <= shreg >> 1;
      end
      if (bit_tick) cnt <= (state_n == state) ? cnt + 1'b1 : '0;
    end
  end

  // Handshake only on a bit boundary so each frame starts on bit_tick and
  // the next frame follows the last stop bit with no gap.
  always_comb begin
    state_n = state;
    txd_n   = txd;
    ready   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      TX_IDLE: if (bit_tick) begin
        ready = 1'b1;
        if (valid) begin
          load    = 1'b1;
          state_n = TX_START;
          txd_n   = 1'b0;
        end
      end
      TX_START: if (bit_tick) begin
        state_n = TX_DATA;
        txd_n   = shreg[0];
      end
      TX_DATA: if (bit_tick) begin
        if (cnt == 4'(DATA_BITS-1)) begin
          if (PARITY_MODE == uart_pkg::PARITY_NONE) begin
            state_n = TX_STOP;
            txd_n   = 1'b1;
          end else begin
            state_n = TX_PARITY;
            txd_n   = par_bit;
          end
        end else begin
          shift = 1'b1;
          txd_n = shreg[1];
        end
      end
      TX_PARITY: if (bit_tick) begin
        state_n = TX_STOP;
        txd_n   = 1'b1;
      end
      TX_STOP: if (bit_tick && cnt == 4'(STOP_BITS-1)) begin
        ready = 1'b1;
        if (valid) begin
          load    = 1'b1;
          state_n = TX_START;
          txd_n   = 1'b0;
        end else begin
          state_n = TX_IDLE;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  assign busy = (state != TX_IDLE);
endmodule

module uart_rx #(
  parameter int unsigned       OSR         = 16,
  parameter int unsigned       DATA_BITS   = 8,
  parameter uart_pkg::parity_e PARITY_MODE = uart_pkg::PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 osr_tick,
  input  logic                 rxd,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err
);
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  localparam int unsigned CW = $clog2(OSR);

  rx_state_e            state, state_n;
  logic [1:0]           sync;
  logic                 rxs, sample, at_end, done, par_bit;
  logic [CW-1:0]        tcnt;
  logic [3:0]           bcnt;
  logic [DATA_BITS-1:0] shreg;

  assign rxs    = sync[1];
  assign at_end = osr_tick && (tcnt == CW'(OSR-1));
  assign data   = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      sync       <= 2'b11;
      tcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state <= state_n;
      sync  <= {sync[0], rxd};
      if (osr_tick) tcnt <= (state_n != state || sample) ? '0 : tcnt + 1'b1;
      if (state == RX_START) bcnt <= '0;
      else if (sample) bcnt <= bcnt + 1'b1;
      if (sample) shreg <= {rxs, shreg[DATA_BITS-1:1]};
      if (state == RX_PARITY && at_end) par_bit <= rxs;
      valid      <= done;
      parity_err <= done && (PARITY_MODE != uart_pkg::PARITY_NONE) &&
                    ((^shreg ^ par_bit) != (PARITY_MODE == uart_pkg::PARITY_ODD));
      frame_err  <= done && !rxs;
    end
  end

  // Only the first stop bit is checked; any further stop time is line idle.
  always_comb begin
    state_n = state;
    sample  = 1'b0;
    done    = 1'b0;
    case (state)
      RX_IDLE:  if (osr_tick && !rxs) state_n = RX_START;
      RX_START: if (osr_tick && tcnt == CW'(OSR/2-1)) state_n = rxs ? RX_IDLE : RX_DATA;
      RX_DATA: if (at_end) begin
        sample = 1'b1;
        if (bcnt == 4'(DATA_BITS-1))
          state_n = (PARITY_MODE == uart_pkg::PARITY_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: if (at_end) state_n = RX_STOP;
      RX_STOP: if (at_end) begin
        done    = 1'b1;
        state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

module uart_fifo_top #(
  parameter int unsigned       OSR         = 16,
  parameter int unsigned       DATA_BITS   = 8,
  parameter int unsigned       STOP_BITS   = 1,
  parameter uart_pkg::parity_e PARITY_MODE = uart_pkg::PARITY_NONE,
  parameter int unsigned       TX_DEPTH    = 16,
  parameter int unsigned       RX_DEPTH    = 16,
  parameter int unsigned       DIV_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIV_W-1:0]           baud_div,
  input  logic                       rxd,
  output logic                       txd,
  input  logic                       tx_valid,
  input  logic [DATA_BITS-1:0]       tx_data,
  output logic                       tx_ready,
  output logic                       rx_valid,
  output logic [DATA_BITS-1:0]       rx_data,
  input  logic                       rx_ready,
  output logic [$clog2(TX_DEPTH):0]  tx_level,
  output logic [$clog2(RX_DEPTH):0]  rx_level,
  output logic                       tx_idle,
  input  logic                       err_clr,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overrun_err
);
  logic [DIV_W-1:0]       div_cnt;
  logic [$clog2(OSR)-1:0] osr_cnt;
  logic                   osr_tick, bit_tick;
  logic                   tx_full, tx_empty, eng_ready, eng_busy;
  logic [DATA_BITS-1:0]   tx_head, rx_byte;
  logic                   rx_full, rx_empty, rx_done, rx_perr, rx_ferr;

  // >= lets a lowered baud_div take effect immediately instead of wrapping the counter.
  assign osr_tick = (div_cnt >= baud_div);
  assign bit_tick = osr_tick && (osr_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      osr_cnt <= '0;
    end else begin
      div_cnt <= osr_tick ? '0 : div_cnt + 1'b1;
      if (osr_tick) osr_cnt <= osr_cnt + 1'b1;
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid), .pop(eng_ready && !tx_empty),
    .wdata(tx_data), .rdata(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  uart_tx #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .PARITY_MODE(PARITY_MODE)) u_tx (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .valid(!tx_empty), .data(tx_head),
    .ready(eng_ready), .busy(eng_busy), .txd(txd)
  );

  uart_rx #(.OSR(OSR), .DATA_BITS(DATA_BITS), .PARITY_MODE(PARITY_MODE)) u_rx (
    .clk(clk), .rst_n(rst_n), .osr_tick(osr_tick), .rxd(rxd), .valid(rx_done),
    .data(rx_byte), .parity_err(rx_perr), .frame_err(rx_ferr)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_done), .pop(rx_ready),
    .wdata(rx_byte), .rdata(rx_data), .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tx_idle  = tx_empty && !eng_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= (rx_done && rx_perr) || (parity_err && !err_clr);
      frame_err   <= (rx_done && rx_ferr) || (frame_err && !err_clr);
      overrun_err <= (rx_done && rx_full) || (overrun_err && !err_clr);
    end
  end
endmodule

// File: doc/uart_fifo_top.md
Name: uart_fifo_top

Overview:
Next-generation UART top. Baud rate is programmable at run time through an integer divisor, not fixed by CLOCK_HZ/BAUD_RATE parameters. TX and RX each have a parametrised show-ahead FIFO, with level/status outputs and sticky error flags. The block instantiates the existing uart_tx and uart_rx engines and sits between the system stream interfaces and the serial pins.

Parameters:
OSR, 16, oversample ticks per bit; power of 2, ≥ 8.
DATA_BITS, 8, data bits per frame (5..9).
STOP_BITS, 1, stop bits (1 or 2).
PARITY_MODE, PARITY_NONE, parity_e from uart_pkg.
TX_DEPTH, 16, TX FIFO entries; power of 2, ≥ 2.
RX_DEPTH, 16, RX FIFO entries; power of 2, ≥ 2.
DIV_W, 16, width of baud_div.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; asynchronous, active-low.
baud_div  in  DIV_W  clocks per osr_tick minus 1.
rxd  in  1  serial input.
txd  out  1  serial output.
tx_valid  in  1  TX write request.
tx_data  in  DATA_BITS  TX write data.
tx_ready  out  1  TX FIFO not full.
rx_valid  out  1  RX FIFO not empty.
rx_data  out  DATA_BITS  RX FIFO head.
rx_ready  in  1  RX pop.
tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
tx_idle  out  1  TX FIFO empty and no frame on txd.
err_clr  in  1  clears sticky error flags.
parity_err  out  1  sticky parity error.
frame_err  out  1  sticky framing error.
overrun_err  out  1  sticky RX FIFO overrun.

Behaviour:
- Reset values: txd=1, tx_ready=1, rx_valid=0, rx_data=0, levels=0, tx_idle=1, all error flags=0.
- Reset clears FIFO pointers, the baud counter and the engines. This applies immediately, including mid-frame.
- Baud generator: div_cnt counts 0..baud_div. osr_tick is a 1-cycle pulse when div_cnt≥baud_div; div_cnt then returns to 0.
  - Using ≥ means that lowering baud_div below div_cnt wraps on the next cycle.
  - baud_div=0 gives osr_tick every cycle.
  - bit_tick pulses on every OSR-th osr_tick, from a separate 0..OSR-1 counter.
  - Bit period = (baud_div+1)*OSR clocks.
- TX path:
  - Push when tx_valid&&tx_ready. tx_ready = !tx_full.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - The FIFO head feeds uart_tx: the pop happens on the uart_tx valid/ready handshake.
  - The first start bit begins at the next bit_tick after the data reaches the head. Frames are sent back-to-back while data remains.
  - tx_level updates the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
  - tx_idle=1 only when the FIFO is empty and uart_tx is ready (last stop bit complete).
- RX path:
  - uart_rx runs with rx_ready tied 1. Each completed frame asserts a 1-cycle internal valid.
  - If the RX FIFO is not full, the byte is written even when parity/frame errors are present.
  - If the RX FIFO is full, the byte is dropped and overrun_err is set. A pop in the same cycle does not make room.
  - rx_valid = !rx_empty. rx_data is the head, valid whenever rx_valid=1. Pop on rx_valid&&rx_ready.
  - Zero-latency show-ahead: the new head is visible the cycle after a pop.
- Error flags: set on the internal per-frame error pulse and held until err_clr=1. If set and clear occur in the same cycle, set wins.
- Level arithmetic: unsigned, no wrap. Pointers are $clog2(DEPTH) wide and wrap naturally. Full/empty come from the level, or from pointers plus a wrap bit.
- baud_div change mid-frame: allowed, no glitch protection. The bit in progress takes mixed timing; the bench checks only frames sent after tx_idle.

Test Plan:
- Basic TX: baud_div=3, OSR=16 (64 clk/bit), push 0xA5 → txd start bit, then 1,0,1,0,0,1,0,1 (LSB first), then stop. Each bit is held exactly 64 clocks. tx_idle returns to 1 after the stop bit.
- TX burst/full: TX_DEPTH=16, push 17 bytes back-to-back → tx_ready=0 once full and tx_level=16. Exactly one push is rejected. Frames are then emitted back-to-back with no idle gap. Pushes are accepted again after the first pop.
- RX loopback: txd→rxd, send 0x00, 0xFF, 0x3C → rx_level=3. rx_data reads 0x00, 0xFF, 0x3C in that order with rx_ready pulsed. No error flags set.
- Overrun: RX_DEPTH=4, rx_ready=0, loop back 5 bytes → rx_level=4 and overrun_err=1. FIFO contents are the first 4 bytes. err_clr clears the flag.
- Errors: PARITY_EVEN, drive a frame with wrong parity, then one with stop=0 → parity_err=1, then frame_err=1, both sticky. Both bytes are present in the RX FIFO.
- Reset mid-frame/baud change: assert rst_n=0 during bit 3 of a TX frame → txd=1 and levels=0 asynchronously. After reset, baud_div=0 gives 16 clk/bit.
